// File: rtl/conv_bram_loader_if.sv
// Valid/ready 32-bit word stream feeding conv_bram_loader.
// master = word source, slave = loader.
interface conv_bram_loader_if;
  logic [31:0] s_data;
  logic        s_valid;
  logic        s_ready;

  modport master (
    output s_data,
    output s_valid,
    input  s_ready
  );

  modport slave (
    input  s_data,
    input  s_valid,
    output s_ready
  );
endinterface

// File: rtl/conv_bram_loader.sv
// Write-side initiator for the CONV shared BRAM port: IFM words, then weights gathered 16-wide.
// Optional running checksum of accepted words: define LOADER_CHECKSUM_EN.
module conv_bram_loader #(
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 20
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [CNT_W-1:0]  ifm_words,
  input  logic [CNT_W-1:0]  weight_words,
  conv_bram_loader_if.slave s,
  output logic [ADDR_W-1:0] addr,
  output logic              we_IFM,
  output logic              we_weight,
  output logic [31:0]       data_in_IFM,
  output logic [31:0]       data_in_Weight_0,
  output logic [31:0]       data_in_Weight_1,
  output logic [31:0]       data_in_Weight_2,
  output logic [31:0]       data_in_Weight_3,
  output logic [31:0]       data_in_Weight_4,
  output logic [31:0]       data_in_Weight_5,
  output logic [31:0]       data_in_Weight_6,
  output logic [31:0]       data_in_Weight_7,
  output logic [31:0]       data_in_Weight_8,
  output logic [31:0]       data_in_Weight_9,
  output logic [31:0]       data_in_Weight_10,
  output logic [31:0]       data_in_Weight_11,
  output logic [31:0]       data_in_Weight_12,
  output logic [31:0]       data_in_Weight_13,
  output logic [31:0]       data_in_Weight_14,
  output logic [31:0]       data_in_Weight_15,
  output logic              cal_start,
  output logic              busy,
  output logic [31:0]       checksum
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_LOAD_IFM = 3'd1,
    S_GATHER   = 3'd2,
    S_COMMIT   = 3'd3,
    S_START    = 3'd4
  } state_e;

  state_e             state_q;
  logic               s_ready_q;
  logic               busy_q;
  logic               cal_start_q;
  logic               we_ifm_q;
  logic               we_weight_q;
  logic [ADDR_W-1:0]  addr_q;
  logic [31:0]        data_ifm_q;
  logic [CNT_W-1:0]   ifm_words_q;
  logic [CNT_W-1:0]   weight_words_q;
  logic [CNT_W-1:0]   ifm_idx_q;
  logic [CNT_W-1:0]   w_idx_q;
  logic [3:0]         j_q;
  logic [31:0]        wbuf_q [16];

  logic               accept_s;
  logic               start_acc_s;
  logic               ifm_last_s;
  logic               w_last_s;

  assign accept_s    = s.s_valid & s_ready_q;
  // busy stays high through the cal_start cycle, so a start coinciding with it is dropped
  assign start_acc_s = (state_q == S_IDLE) & start & ~busy_q;
  assign ifm_last_s  = (ifm_idx_q == (ifm_words_q - CNT_W'(1)));
  assign w_last_s    = (w_idx_q == (weight_words_q - CNT_W'(1)));

  // Load sequencer: phase control, address/strobe generation and handshake readiness
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= S_IDLE;
      s_ready_q      <= 1'b0;
      busy_q         <= 1'b0;
      cal_start_q    <= 1'b0;
      we_ifm_q       <= 1'b0;
      we_weight_q    <= 1'b0;
      addr_q         <= '0;
      data_ifm_q     <= 32'd0;
      ifm_words_q    <= '0;
      weight_words_q <= '0;
      ifm_idx_q      <= '0;
      w_idx_q        <= '0;
      j_q            <= 4'd0;
    end else begin
      we_ifm_q    <= 1'b0;
      we_weight_q <= 1'b0;
      cal_start_q <= (state_q == S_START);
      if (cal_start_q) begin
        busy_q <= 1'b0;
      end
      case (state_q)
        S_IDLE: begin
          if (start_acc_s) begin
            ifm_words_q    <= ifm_words;
            weight_words_q <= weight_words;
            busy_q         <= 1'b1;
            ifm_idx_q      <= '0;
            w_idx_q        <= '0;
            j_q            <= 4'd0;
            if (ifm_words != '0) begin
              state_q   <= S_LOAD_IFM;
              s_ready_q <= 1'b1;
            end else if (weight_words != '0) begin
              state_q   <= S_GATHER;
              s_ready_q <= 1'b1;
            end else begin
              state_q   <= S_START;
              s_ready_q <= 1'b0;
            end
          end
        end
        S_LOAD_IFM: begin
          if (accept_s) begin
            we_ifm_q   <= 1'b1;
            addr_q     <= ADDR_W'(ifm_idx_q);
            data_ifm_q <= s.s_data;
            ifm_idx_q  <= ifm_idx_q + CNT_W'(1);
            if (ifm_last_s) begin
              if (weight_words_q != '0) begin
                state_q   <= S_GATHER;
                s_ready_q <= 1'b1;
              end else begin
                state_q   <= S_START;
                s_ready_q <= 1'b0;
              end
            end
          end
        end
        S_GATHER: begin
          if (accept_s) begin
            j_q <= j_q + 4'd1;
            if (j_q == 4'd15) begin
              state_q     <= S_COMMIT;
              s_ready_q   <= 1'b0;
              we_weight_q <= 1'b1;
              addr_q      <= ADDR_W'(w_idx_q);
            end
          end
        end
        S_COMMIT: begin
          w_idx_q <= w_idx_q + CNT_W'(1);
          j_q     <= 4'd0;
          if (w_last_s) begin
            state_q   <= S_START;
            s_ready_q <= 1'b0;
          end else begin
            state_q   <= S_GATHER;
            s_ready_q <= 1'b1;
          end
        end
        S_START: begin
          state_q   <= S_IDLE;
          s_ready_q <= 1'b0;
        end
        default: begin
          state_q   <= S_IDLE;
          s_ready_q <= 1'b0;
        end
      endcase
    end
  end

  // Weight gather buffer; its contents drive the per-bank write data directly
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < 16; k++) begin
        wbuf_q[k] <= 32'd0;
      end
    end else if ((state_q == S_GATHER) && accept_s) begin
      wbuf_q[j_q] <= s.s_data;
    end
  end

`ifdef LOADER_CHECKSUM_EN
  logic [31:0] checksum_q;

  // Modulo-2^32 sum of every word accepted in the current load
  always_ff @(posedge clk) begin
    if (reset) begin
      checksum_q <= 32'd0;
    end else if (start_acc_s) begin
      checksum_q <= 32'd0;
    end else if (accept_s) begin
      checksum_q <= checksum_q + s.s_data;
    end
  end

  assign checksum = checksum_q;
`else
  assign checksum = 32'd0;
`endif

  assign s.s_ready   = s_ready_q;
  assign busy        = busy_q;
  assign cal_start   = cal_start_q;
  assign we_IFM      = we_ifm_q;
  assign we_weight   = we_weight_q;
  assign addr        = addr_q;
  assign data_in_IFM = data_ifm_q;

  assign data_in_Weight_0  = wbuf_q[0];
  assign data_in_Weight_1  = wbuf_q[1];
  assign data_in_Weight_2  = wbuf_q[2];
  assign data_in_Weight_3  = wbuf_q[3];
  assign data_in_Weight_4  = wbuf_q[4];
  assign data_in_Weight_5  = wbuf_q[5];
  assign data_in_Weight_6  = wbuf_q[6];
  assign data_in_Weight_7  = wbuf_q[7];
  assign data_in_Weight_8  = wbuf_q[8];
  assign data_in_Weight_9  = wbuf_q[9];
  assign data_in_Weight_10 = wbuf_q[10];
  assign data_in_Weight_11 = wbuf_q[11];
  assign data_in_Weight_12 = wbuf_q[12];
  assign data_in_Weight_13 = wbuf_q[13];
  assign data_in_Weight_14 = wbuf_q[14];
  assign data_in_Weight_15 = wbuf_q[15];

endmodule

// File: tb/tb_conv_bram_loader.sv
// Directed self-checking bench for conv_bram_loader (inputs driven and outputs sampled 1 time unit after posedge).
module tb_conv_bram_loader;

  logic        clk;
  logic        reset;
  logic        start;
  logic [19:0] ifm_words;
  logic [19:0] weight_words;
  logic [31:0] addr;
  logic        we_IFM;
  logic        we_weight;
  logic [31:0] data_in_IFM;
  logic [31:0] dw [16];
  logic        cal_start;
  logic        busy;
  logic [31:0] checksum;

  int n_checks = 0;
  int n_fail   = 0;

  conv_bram_loader_if bus ();

  conv_bram_loader #(.ADDR_W(32), .CNT_W(20)) dut (
    .clk               (clk),
    .reset             (reset),
    .start             (start),
    .ifm_words         (ifm_words),
    .weight_words      (weight_words),
    .s                 (bus),
    .addr              (addr),
    .we_IFM            (we_IFM),
    .we_weight         (we_weight),
    .data_in_IFM       (data_in_IFM),
    .data_in_Weight_0  (dw[0]),
    .data_in_Weight_1  (dw[1]),
    .data_in_Weight_2  (dw[2]),
    .data_in_Weight_3  (dw[3]),
    .data_in_Weight_4  (dw[4]),
    .data_in_Weight_5  (dw[5]),
    .data_in_Weight_6  (dw[6]),
    .data_in_Weight_7  (dw[7]),
    .data_in_Weight_8  (dw[8]),
    .data_in_Weight_9  (dw[9]),
    .data_in_Weight_10 (dw[10]),
    .data_in_Weight_11 (dw[11]),
    .data_in_Weight_12 (dw[12]),
    .data_in_Weight_13 (dw[13]),
    .data_in_Weight_14 (dw[14]),
    .data_in_Weight_15 (dw[15]),
    .cal_start         (cal_start),
    .busy              (busy),
    .checksum          (checksum)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Present one word and return in the cycle after it is accepted.
  task automatic send(input logic [31:0] w);
    logic acc;
    acc = 1'b0;
    bus.s_valid = 1'b1;
    bus.s_data  = w;
    for (int i = 0; i < 24 && !acc; i++) begin
      acc = bus.s_ready;
      tick();
    end
    check1("word_accepted", acc, 1'b1);
    bus.s_valid = 1'b0;
  endtask

  task automatic check_ifm_write(input string tag, input logic [31:0] a, input logic [31:0] d);
    check1({tag, "_we_ifm"}, we_IFM, 1'b1);
    check1({tag, "_we_weight"}, we_weight, 1'b0);
    check({tag, "_addr"}, addr, a);
    check({tag, "_data"}, data_in_IFM, d);
  endtask

  task automatic check_commit(input string tag, input logic [31:0] a, input logic [31:0] base);
    check1({tag, "_we_weight"}, we_weight, 1'b1);
    check1({tag, "_we_ifm"}, we_IFM, 1'b0);
    check1({tag, "_s_ready"}, bus.s_ready, 1'b0);
    check({tag, "_addr"}, addr, a);
    for (int k = 0; k < 16; k++) begin
      check($sformatf("%s_bank%0d", tag, k), dw[k], base + 32'(k));
    end
  endtask

  task automatic do_start(input logic [19:0] iw, input logic [19:0] ww);
    start        = 1'b1;
    ifm_words    = iw;
    weight_words = ww;
    tick();
    start = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset        = 1'b1;
    start        = 1'b0;
    ifm_words    = 20'd0;
    weight_words = 20'd0;
    bus.s_valid  = 1'b0;
    bus.s_data   = 32'd0;
    tick();
    tick();
    reset = 1'b0;

    // Reset state
    check("rst_addr", addr, 32'd0);
    check1("rst_we_ifm", we_IFM, 1'b0);
    check1("rst_we_weight", we_weight, 1'b0);
    check1("rst_s_ready", bus.s_ready, 1'b0);
    check1("rst_busy", busy, 1'b0);
    check1("rst_cal_start", cal_start, 1'b0);
    check("rst_bank0", dw[0], 32'd0);
    check("rst_checksum", checksum, 32'd0);

    // 1: three IFM words, no weights, continuous valid
    do_start(20'd3, 20'd0);
    check1("t1_busy", busy, 1'b1);
    check1("t1_s_ready", bus.s_ready, 1'b1);
    send(32'hA0);
    check_ifm_write("t1_w0", 32'd0, 32'hA0);
    send(32'hA1);
    check_ifm_write("t1_w1", 32'd1, 32'hA1);
    send(32'hA2);
    check_ifm_write("t1_w2", 32'd2, 32'hA2);
    check1("t1_cal_early", cal_start, 1'b0);
    tick();
    check1("t1_cal", cal_start, 1'b1);
    check1("t1_we_ifm_off", we_IFM, 1'b0);
    check1("t1_we_weight_off", we_weight, 1'b0);
    check1("t1_busy_at_cal", busy, 1'b1);
    check("t1_addr_hold", addr, 32'd2);
    tick();
    check1("t1_cal_off", cal_start, 1'b0);
    check1("t1_busy_off", busy, 1'b0);

    // 2: two weight addresses, 32 words 0x100+n
    do_start(20'd0, 20'd2);
    for (int n = 0; n < 16; n++) send(32'h100 + 32'(n));
    check_commit("t2_c0", 32'd0, 32'h100);
    for (int n = 16; n < 32; n++) send(32'h100 + 32'(n));
    check_commit("t2_c1", 32'd1, 32'h110);
    tick();
    check1("t2_we_weight_off", we_weight, 1'b0);
    check("t2_bank3_hold", dw[3], 32'h113);
    check1("t2_cal_early", cal_start, 1'b0);
    tick();
    check1("t2_cal", cal_start, 1'b1);
    tick();
    check1("t2_busy_off", busy, 1'b0);

    // 3: ifm=2, weight=1 with valid toggled every other cycle
    do_start(20'd2, 20'd1);
    for (int n = 0; n < 18; n++) begin
      send(32'h200 + 32'(n));
      if (n < 2) begin
        check_ifm_write($sformatf("t3_ifm%0d", n), 32'(n), 32'h200 + 32'(n));
      end else if (n == 17) begin
        check_commit("t3_c0", 32'd0, 32'h202);
      end else begin
        check1("t3_no_write_gather", we_IFM | we_weight, 1'b0);
      end
      tick();
      check1($sformatf("t3_gap_we_ifm%0d", n), we_IFM, 1'b0);
    end
    tick();
    check1("t3_cal", cal_start, 1'b1);
    tick();

    // 4: start reasserted mid-load is ignored; start with cal_start is ignored
    do_start(20'd1, 20'd1);
    send(32'h600);
    check_ifm_write("t4_ifm0", 32'd0, 32'h600);
    for (int n = 0; n < 5; n++) send(32'h700 + 32'(n));
    start        = 1'b1;
    ifm_words    = 20'd5;
    weight_words = 20'd3;
    send(32'h705);
    start = 1'b0;
    for (int n = 6; n < 16; n++) send(32'h700 + 32'(n));
    check_commit("t4_c0", 32'd0, 32'h700);
    tick();
    check1("t4_no_more_gather", bus.s_ready, 1'b0);
    check1("t4_busy", busy, 1'b1);
    tick();
    check1("t4_cal", cal_start, 1'b1);
    check1("t4_busy_at_cal", busy, 1'b1);
    start        = 1'b1;
    ifm_words    = 20'd0;
    weight_words = 20'd0;
    tick();
    start = 1'b0;
    check1("t4_busy_off", busy, 1'b0);
    tick();
    check1("t4_late_start_ignored", cal_start, 1'b0);
    check1("t4_still_idle", busy, 1'b0);

    // 5: reset during gather at j=7, then a fresh load
    do_start(20'd0, 20'd1);
    for (int n = 0; n < 7; n++) send(32'h300 + 32'(n));
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("t5_rst_addr", addr, 32'd0);
    check("t5_rst_ifm_data", data_in_IFM, 32'd0);
    check("t5_rst_bank0", dw[0], 32'd0);
    check("t5_rst_bank6", dw[6], 32'd0);
    check1("t5_rst_busy", busy, 1'b0);
    check1("t5_rst_s_ready", bus.s_ready, 1'b0);
    tick();
    check1("t5_post_rst_we", we_IFM | we_weight, 1'b0);
    do_start(20'd1, 20'd1);
    send(32'h400);
    check_ifm_write("t5_ifm0", 32'd0, 32'h400);
    for (int n = 0; n < 16; n++) send(32'h500 + 32'(n));
    check_commit("t5_c0", 32'd0, 32'h500);
    tick();
    tick();
    check1("t5_cal", cal_start, 1'b1);
    tick();

    // 6: empty load, cal_start two cycles after start
    do_start(20'd0, 20'd0);
    check1("t6_cal_c1", cal_start, 1'b0);
    check1("t6_busy", busy, 1'b1);
    tick();
    check1("t6_cal_c2", cal_start, 1'b1);
    check1("t6_no_write", we_IFM | we_weight, 1'b0);
    tick();
    check1("t6_busy_off", busy, 1'b0);

    // 7: checksum over 1, 2, 0xFFFFFFFF
    do_start(20'd3, 20'd0);
    send(32'd1);
    send(32'd2);
    send(32'hFFFF_FFFF);
    check_ifm_write("t7_w2", 32'd2, 32'hFFFF_FFFF);
    tick();
    check1("t7_cal", cal_start, 1'b1);
`ifdef LOADER_CHECKSUM_EN
    check("t7_checksum", checksum, 32'h0000_0002);
`else
    check("t7_checksum", checksum, 32'h0000_0000);
`endif
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
